// File: rtl/fnd_source_arbiter.sv
// fnd_source_arbiter: picks which display source drives the shared FND pins.
// Manual select or auto-rotation over enabled channels; every change of
// source passes through a fixed blanking interval to avoid ghosting.
// All pin-facing outputs are registered.
module fnd_source_arbiter #(
  parameter int N_CH      = 3,
  parameter int COM_W     = 4,
  parameter int DATA_W    = 8,
  parameter int BLANK_CYC = 4,
  parameter int DWELL_CYC = 50000000,
  parameter int SEL_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*COM_W-1:0]   com_bus,
  input  logic [N_CH*DATA_W-1:0]  data_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    auto_en,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [DATA_W-1:0]       fnd_data,
  output logic [COM_W-1:0]        fnd_com,
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    switching
);

  localparam int DW_W = $clog2(DWELL_CYC);
  localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [BC_W-1:0] BLANK_LOAD = BC_W'(BLANK_CYC - 1);
  localparam logic [N_CH-1:0] MASK_ONE   = N_CH'(1'b1);

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t              state_r;
  logic [SEL_W-1:0]    cur_ch_r;
  logic [BC_W-1:0]     blank_cnt_r;
  logic [DW_W-1:0]     dwell_cnt_r;
  logic [DATA_W-1:0]   fnd_data_r;
  logic [COM_W-1:0]    fnd_com_r;
  logic                switching_r;

  logic [DATA_W-1:0]   slice_data_s;
  logic [COM_W-1:0]    slice_com_s;
  logic                cur_en_s;
  logic [SEL_W-1:0]    next_ch_s;
  logic                found_s;
  logic                hit_s;
  int                  cand_s;
  logic                dwell_exp_s;
  logic                sel_valid_s;
  logic [SEL_W-1:0]    target_s;

  assign fnd_data  = fnd_data_r;
  assign fnd_com   = fnd_com_r;
  assign cur_ch    = cur_ch_r;
  assign switching = switching_r;

  assign dwell_exp_s = (dwell_cnt_r == DWELL_LAST);
  assign sel_valid_s = (sel != '0) && (sel <= SEL_W'(N_CH));

  // Extract the current channel's bus slices (blank pattern for channel 0) and its mask bit.
  always_comb begin
    slice_data_s = '0;
    slice_com_s  = '1;
    cur_en_s     = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      slice_data_s = (cur_ch_r == SEL_W'(k)) ? DATA_W'(data_bus >> ((k - 1) * DATA_W)) : slice_data_s;
      slice_com_s  = (cur_ch_r == SEL_W'(k)) ? COM_W'(com_bus >> ((k - 1) * COM_W)) : slice_com_s;
      cur_en_s     = (cur_ch_r == SEL_W'(k)) ? |(ch_mask & (MASK_ONE << (k - 1))) : cur_en_s;
    end
  end

  // Find the next enabled channel ascending from cur_ch+1, wrapping N_CH -> 1 (may land on cur_ch itself).
  always_comb begin
    next_ch_s = '0;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    cand_s    = 0;
    for (int i = 1; i <= N_CH; i++) begin
      cand_s = int'(cur_ch_r) + i;
      if (cand_s > N_CH) begin
        cand_s = cand_s - N_CH;
      end else begin
        cand_s = cand_s;
      end
      hit_s = |(ch_mask & (MASK_ONE << (cand_s - 1)));
      if (hit_s && !found_s) begin
        next_ch_s = SEL_W'(cand_s);
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Decide which channel should be on the pins this cycle.
  always_comb begin
    target_s = '0;
    if (!auto_en) begin
      if (sel_valid_s) begin
        target_s = sel;
      end else begin
        target_s = '0;
      end
    end else if (ch_mask == '0) begin
      target_s = '0;
    end else if (cur_en_s && !dwell_exp_s) begin
      target_s = cur_ch_r;
    end else begin
      target_s = next_ch_s;
    end
  end

  // SHOW/BLANK state machine with registered pin outputs and dwell/blank counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_SHOW;
      cur_ch_r    <= '0;
      blank_cnt_r <= '0;
      dwell_cnt_r <= '0;
      fnd_data_r  <= '0;
      fnd_com_r   <= '1;
      switching_r <= 1'b0;
    end else begin
      case (state_r)
        ST_SHOW: begin
          // An expired dwell that stays on the same channel restarts; one that leaves is held
          // so the rotation target stays stable through the blank.
          if (!auto_en) begin
            dwell_cnt_r <= '0;
          end else if (!dwell_exp_s) begin
            dwell_cnt_r <= dwell_cnt_r + DW_W'(1);
          end else if (target_s == cur_ch_r) begin
            dwell_cnt_r <= '0;
          end else begin
            dwell_cnt_r <= dwell_cnt_r;
          end
          if (target_s == cur_ch_r) begin
            fnd_data_r  <= slice_data_s;
            fnd_com_r   <= slice_com_s;
            switching_r <= 1'b0;
          end else begin
            state_r     <= ST_BLANK;
            blank_cnt_r <= BLANK_LOAD;
            fnd_data_r  <= '0;
            fnd_com_r   <= '1;
            switching_r <= 1'b1;
          end
        end
        ST_BLANK: begin
          fnd_data_r <= '0;
          fnd_com_r  <= '1;
          if (blank_cnt_r == '0) begin
            // Land on the latest requested channel so chatter never adds latency.
            cur_ch_r    <= target_s;
            state_r     <= ST_SHOW;
            switching_r <= 1'b0;
            dwell_cnt_r <= '0;
          end else begin
            blank_cnt_r <= blank_cnt_r - BC_W'(1);
            if (!auto_en) begin
              dwell_cnt_r <= '0;
            end else begin
              dwell_cnt_r <= dwell_cnt_r;
            end
          end
        end
        default: begin
          state_r     <= ST_SHOW;
          cur_ch_r    <= '0;
          blank_cnt_r <= '0;
          dwell_cnt_r <= '0;
          fnd_data_r  <= '0;
          fnd_com_r   <= '1;
          switching_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
